// File: rtl/cv32e40px_x_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40px_x_issue_arb
// Brief    : Shares one CORE-V-XIF coprocessor between NUM_REQ cores: issue
//            arbitration, ID renaming, commit generation and result routing.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40px_x_issue_arb #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 64,
    parameter int RES_W     = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_issue_valid_i,
    output logic [NUM_REQ-1:0]                 req_issue_ready_o,
    input  logic [NUM_REQ-1:0][3:0]            req_issue_id_i,
    input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0]  req_issue_payload_i,
    output logic                               req_issue_resp_accept_o,
    output logic                               req_issue_resp_writeback_o,
    output logic                               cop_issue_valid_o,
    input  logic                               cop_issue_ready_i,
    output logic [3:0]                         cop_issue_id_o,
    output logic [PAYLOAD_W-1:0]               cop_issue_payload_o,
    input  logic                               cop_issue_resp_accept_i,
    input  logic                               cop_issue_resp_writeback_i,
    output logic                               cop_commit_valid_o,
    output logic [3:0]                         cop_commit_id_o,
    output logic                               cop_commit_kill_o,
    input  logic                               cop_result_valid_i,
    output logic                               cop_result_ready_o,
    input  logic [3:0]                         cop_result_id_i,
    input  logic [RES_W-1:0]                   cop_result_payload_i,
    output logic [NUM_REQ-1:0]                 req_result_valid_o,
    input  logic [NUM_REQ-1:0]                 req_result_ready_i,
    output logic [3:0]                         req_result_id_o,
    output logic [RES_W-1:0]                   req_result_payload_o,
    output logic [4:0]                         occupancy_o,
    output logic                               err_orphan_o
);

    localparam int              c_own_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              c_depth = 16;
    localparam logic [c_own_w-1:0] c_last = c_own_w'(NUM_REQ - 1);

    logic [c_own_w-1:0] r_rr;
    logic [c_own_w-1:0] r_lock_gnt;
    logic               r_lock;
    logic [3:0]         r_next_id;
    logic [c_depth-1:0] r_tbl_valid;
    logic [c_own_w-1:0] r_tbl_owner [c_depth];
    logic [3:0]         r_tbl_orig  [c_depth];
    logic [4:0]         r_occ;
    logic               r_err_orphan;

    logic [c_own_w-1:0] w_cand;
    logic [c_own_w-1:0] w_rr_gnt;
    logic               w_found;
    logic [c_own_w-1:0] w_grant;
    logic               w_full;
    logic               w_hs;
    logic               w_alloc;
    logic               w_res_hit;
    logic [c_own_w-1:0] w_res_owner;
    logic               w_free;
    logic               w_orphan;

    // First requester at or after r_rr, scanning circularly.
    always_comb begin
        w_rr_gnt = r_rr;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = c_own_w'((int'(r_rr) + i) % NUM_REQ);
            if (!w_found && req_issue_valid_i[w_cand]) begin
                w_rr_gnt = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_grant           = r_lock ? r_lock_gnt : w_rr_gnt;
    assign w_full            = r_tbl_valid[r_next_id];
    assign cop_issue_valid_o = (|req_issue_valid_i) & ~w_full;
    assign w_hs              = cop_issue_valid_o & cop_issue_ready_i;
    assign w_alloc           = w_hs & cop_issue_resp_accept_i;

    always_comb begin
        req_issue_ready_o = '0;
        if (cop_issue_valid_o) begin
            req_issue_ready_o[w_grant] = cop_issue_ready_i;
        end
    end

    assign cop_issue_id_o             = r_next_id;
    assign cop_issue_payload_o        = cop_issue_valid_o ? req_issue_payload_i[w_grant] : '0;
    assign req_issue_resp_accept_o    = cop_issue_resp_accept_i;
    assign req_issue_resp_writeback_o = cop_issue_resp_writeback_i;
    assign cop_commit_valid_o         = w_hs;
    assign cop_commit_id_o            = r_next_id;
    assign cop_commit_kill_o          = 1'b0;

    assign w_res_hit   = r_tbl_valid[cop_result_id_i];
    assign w_res_owner = r_tbl_owner[cop_result_id_i];

    // Results for unknown IDs are swallowed so the coprocessor never stalls.
    always_comb begin
        req_result_valid_o = '0;
        cop_result_ready_o = 1'b0;
        req_result_id_o    = '0;
        if (cop_result_valid_i) begin
            if (w_res_hit) begin
                req_result_valid_o[w_res_owner] = 1'b1;
                cop_result_ready_o              = req_result_ready_i[w_res_owner];
                req_result_id_o                 = r_tbl_orig[cop_result_id_i];
            end else begin
                cop_result_ready_o = 1'b1;
            end
        end
    end

    assign req_result_payload_o = cop_result_payload_i;
    assign w_free   = cop_result_valid_i & w_res_hit & req_result_ready_i[w_res_owner];
    assign w_orphan = cop_result_valid_i & ~w_res_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr         <= '0;
            r_lock       <= 1'b0;
            r_lock_gnt   <= '0;
            r_next_id    <= '0;
            r_tbl_valid  <= '0;
            r_occ        <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_err_orphan <= w_orphan;
            r_occ        <= r_occ + {4'd0, w_alloc} - {4'd0, w_free};
            if (w_hs) begin
                r_lock    <= 1'b0;
                r_rr      <= (w_grant == c_last) ? '0 : w_grant + 1'b1;
                r_next_id <= r_next_id + 4'd1;
            end else if (cop_issue_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_gnt <= w_grant;
            end
            // Alloc target is never valid and free target always is, so they differ.
            if (w_free) begin
                r_tbl_valid[cop_result_id_i] <= 1'b0;
            end
            if (w_alloc) begin
                r_tbl_valid[r_next_id] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_tbl_owner[r_next_id] <= w_grant;
            r_tbl_orig[r_next_id]  <= req_issue_id_i[w_grant];
        end
    end

    assign occupancy_o  = r_occ;
    assign err_orphan_o = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_x_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40px_x_issue_arb
// Brief    : Directed and randomized bench against a table-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40px_x_issue_arb;
    localparam int N  = 2;
    localparam int PW = 64;
    localparam int RW = 32;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    logic [N-1:0] iv, ir;
    logic [N-1:0][3:0] iid;
    logic [N-1:0][PW-1:0] ipl;
    logic acc_o, wb_o, cv, cr, cacc, cwb;
    logic [3:0] cid, comid;
    logic [PW-1:0] cpl;
    logic comv, kill, rv, rrdy, orph;
    logic [3:0] rid, qid;
    logic [RW-1:0] rpl, qpl;
    logic [N-1:0] qv, qr;
    logic [4:0] occ;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: per-ID table plus arbitration bookkeeping.
    bit m_v[16];
    int m_own[16];
    int m_orig[16];
    int m_rr, m_lgnt, m_nid, m_hg;
    bit m_lock, m_orph, m_hs;

    always #5 clk = ~clk;

    cv32e40px_x_issue_arb #(.NUM_REQ(N), .PAYLOAD_W(PW), .RES_W(RW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_issue_valid_i(iv), .req_issue_ready_o(ir),
        .req_issue_id_i(iid), .req_issue_payload_i(ipl),
        .req_issue_resp_accept_o(acc_o), .req_issue_resp_writeback_o(wb_o),
        .cop_issue_valid_o(cv), .cop_issue_ready_i(cr),
        .cop_issue_id_o(cid), .cop_issue_payload_o(cpl),
        .cop_issue_resp_accept_i(cacc), .cop_issue_resp_writeback_i(cwb),
        .cop_commit_valid_o(comv), .cop_commit_id_o(comid), .cop_commit_kill_o(kill),
        .cop_result_valid_i(rv), .cop_result_ready_o(rrdy),
        .cop_result_id_i(rid), .cop_result_payload_i(rpl),
        .req_result_valid_o(qv), .req_result_ready_i(qr),
        .req_result_id_o(qid), .req_result_payload_o(qpl),
        .occupancy_o(occ), .err_orphan_o(orph)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant();
        if (m_lock) return m_lgnt;
        for (int k = 0; k < N; k++) begin
            if (iv[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return m_rr;
    endfunction

    task automatic mreset();
        for (int j = 0; j < 16; j++) m_v[j] = 1'b0;
        m_rr = 0; m_lock = 1'b0; m_lgnt = 0; m_nid = 0; m_orph = 1'b0; m_hs = 1'b0; m_hg = 0;
    endtask

    task automatic check_all();
        int g, cnt;
        bit any, full;
        g = mgrant(); any = |iv; full = m_v[m_nid]; cnt = 0;
        for (int j = 0; j < 16; j++) cnt += int'(m_v[j]);
        chk("cop_valid", cv, any && !full);
        chk("issue_ready", ir, (any && cr && !full) ? (64'd1 << g) : 64'd0);
        chk("cop_id", cid, m_nid);
        chk("cop_payload", cpl, (any && !full) ? ipl[g] : 64'd0);
        chk("commit_valid", comv, any && !full && cr);
        chk("commit_id", comid, m_nid);
        chk("commit_kill", kill, 0);
        chk("accept_pass", acc_o, cacc);
        chk("wb_pass", wb_o, cwb);
        if (rv && m_v[rid]) begin
            chk("res_valid", qv, 64'd1 << m_own[rid]);
            chk("res_ready", rrdy, qr[m_own[rid]]);
            chk("res_id", qid, m_orig[rid]);
        end else begin
            chk("res_valid", qv, 0);
            chk("res_ready", rrdy, rv);
            chk("res_id", qid, 0);
        end
        chk("res_payload", qpl, rpl);
        chk("occupancy", occ, cnt);
        chk("orphan", orph, m_orph);
    endtask

    // Check settled outputs, then advance model and DUT by one clock.
    task automatic tick();
        int g, fidx;
        bit any, full, cvx, hs, fr, on;
        #1;
        check_all();
        g = mgrant(); any = |iv; full = m_v[m_nid]; cvx = any && !full; hs = cvx && cr;
        fr = rv && m_v[rid] && qr[m_own[rid]]; fidx = int'(rid); on = rv && !m_v[rid];
        @(posedge clk);
        if (fr) m_v[fidx] = 1'b0;
        if (hs) begin
            if (cacc) begin
                m_v[m_nid] = 1'b1; m_own[m_nid] = g; m_orig[m_nid] = int'(iid[g]);
            end
            m_nid = (m_nid + 1) % 16;
            m_rr = (g + 1) % N;
            m_lock = 1'b0;
        end else if (cvx) begin
            m_lock = 1'b1; m_lgnt = g;
        end
        m_orph = on; m_hs = hs; m_hg = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        iv = '0; cr = 1'b0; cacc = 1'b0; cwb = 1'b0; rv = 1'b0; rid = '0; qr = '0; rpl = '0;
        rst_ni = 1'b0;
        #1;
        mreset();
        check_all();
        chk("rst_occ", occ, 0);
        chk("rst_id", cid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        iv = '0; iid = '0; ipl = '0; qr = '0;
        do_reset();

        // Round-robin with continuous requests
        iv = 2'b11; cr = 1'b1; cacc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iid[0] = 4'(k); iid[1] = 4'(k + 8);
            #1;
            chk("rr_ready", ir, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_id", cid, k);
            chk("rr_commit", comv, 1);
            tick();
        end

        // Grant held while the coprocessor stalls
        do_reset();
        ipl[0] = 64'hA; ipl[1] = 64'hB; iv = 2'b10; cacc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) iv = 2'b11;
            if (k == 3) cr = 1'b1;
            #1;
            chk("lock_payload", cpl, 64'hB);
            chk("lock_ready", ir, (k == 3) ? 2'b10 : 2'b00);
            tick();
        end
        iv = 2'b01;
        #1;
        chk("lock_after_ready", ir, 2'b01);
        chk("lock_after_payload", cpl, 64'hA);
        tick();

        // Rejects, renaming to ID 5 and back-pressured routing
        do_reset();
        iv = 2'b01; cr = 1'b1; cacc = 1'b0;
        repeat (5) tick();
        #1;
        chk("reject_occ", occ, 0);
        chk("reject_id", cid, 5);
        iv = 2'b10; iid[1] = 4'd9; cacc = 1'b1;
        tick();
        iv = '0; cacc = 1'b0; rv = 1'b1; rid = 4'd5; qr = 2'b00; rpl = $urandom;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("route_stall_ready", rrdy, 0);
            chk("route_valid", qv, 2'b10);
            tick();
        end
        qr = 2'b10;
        #1;
        chk("route_ready", rrdy, 1);
        chk("route_id", qid, 9);
        chk("route_occ_before", occ, 1);
        tick();
        rv = 1'b0;
        #1;
        chk("route_occ_after", occ, 0);
        rv = 1'b1; rid = 4'd2; qr = '0;
        #1;
        chk("orphan_ready", rrdy, 1);
        chk("orphan_valid", qv, 0);
        tick();
        rv = 1'b0;
        #1;
        chk("orphan_pulse", orph, 1);
        tick();
        #1;
        chk("orphan_clear", orph, 0);

        // Fill all 16 entries, then free ID 0 and wrap
        do_reset();
        iv = 2'b01; cr = 1'b1; cacc = 1'b1;
        repeat (16) tick();
        #1;
        chk("full_occ", occ, 16);
        chk("full_valid", cv, 0);
        chk("full_ready", ir, 0);
        rv = 1'b1; rid = 4'd0; qr = 2'b01;
        #1;
        chk("free_no_bypass", cv, 0);
        tick();
        rv = 1'b0;
        #1;
        chk("wrap_valid", cv, 1);
        chk("wrap_id", cid, 0);
        tick();

        // Reset with three instructions outstanding
        do_reset();
        iv = 2'b11; cr = 1'b1; cacc = 1'b1;
        repeat (3) tick();
        iv = '0;
        #1;
        chk("pre_reset_occ", occ, 3);
        do_reset();
        rv = 1'b1; rid = 4'd1; qr = 2'b11;
        #1;
        chk("stale_ready", rrdy, 1);
        chk("stale_valid", qv, 0);
        tick();
        rv = 1'b0;
        #1;
        chk("stale_orphan", orph, 1);
        tick();

        // Randomized traffic; requesters hold valid and payload until granted
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!iv[i]) begin
                    iv[i] = 1'($urandom); iid[i] = 4'($urandom); ipl[i] = {$urandom, $urandom};
                end
            end
            cr = ($urandom % 4) != 0; cacc = ($urandom % 4) != 0; cwb = 1'($urandom);
            rv = 1'($urandom); rid = 4'($urandom); qr = N'($urandom); rpl = $urandom;
            tick();
            if (m_hs) iv[m_hg] = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
